mult_sequencer: RTL and testbench

Control sequencer for the N-bit unsigned shift-add multiplier datapath, i.e. the C/A/Q accumulator register plus adder. It accepts a start request and drives the register's load, add and shift strobes for N bit-steps, sampling the multiplier LSB each step. It reports completion with a done pulse and a held result-valid flag. The block sits between the top-level request logic and the accumulator register; it contains no datapath arithmetic.

---
 rtl/mult_sequencer.sv | 93 +++++++++
 tb/tb_mult_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_sequencer.sv
// mult_sequencer: control FSM for an N-bit unsigned shift-add multiplier.
// Issues one load, then N add-or-shift strobes keyed on q0, then a done pulse.
module mult_sequencer #(
  parameter int N  = 8,
  parameter int CW = $clog2(N+1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          q0,
  output logic          load,
  output logic          add,
  output logic          shift,
  output logic          busy,
  output logic          ready,
  output logic          done,
  output logic          valid,
  output logic [CW-1:0] step
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CW-1:0] STEP_LAST = CW'(N - 1);
  localparam logic [CW-1:0] STEP_SAT  = CW'(N);

  state_t        state;
  state_t        state_nxt;
  logic          valid_nxt;
  logic [CW-1:0] step_nxt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      valid <= 1'b0;
      step  <= '0;
    end else begin
      state <= state_nxt;
      valid <= valid_nxt;
      step  <= step_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    valid_nxt = valid;
    step_nxt  = step;
    load      = 1'b0;
    add       = 1'b0;
    shift     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        load      = 1'b1;
        state_nxt = abort ? IDLE : RUN;
      end
      RUN: begin
        // An aborted step issues no strobe and does not count as completed
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          add   = q0;
          shift = ~q0;
          if (step != STEP_SAT) step_nxt = step + CW'(1);
          if (step == STEP_LAST) state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = start ? LOAD : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Entering LOAD starts a fresh operation; entering DONE publishes the result
    if (state_nxt == LOAD) begin
      valid_nxt = 1'b0;
      step_nxt  = '0;
    end
    if (state_nxt == DONE) valid_nxt = 1'b1;
    if (state == RUN && abort) valid_nxt = 1'b0;
  end

  assign busy  = (state == LOAD) || (state == RUN);
  assign ready = (state == IDLE) || (state == DONE);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer: drives the sequencer with an attached C/A/Q register and
// scores each finished operation against a start/abort timeline model.
`timescale 1ns/1ps
module tb_mult_sequencer;
  localparam int N  = 8;
  localparam int CW = $clog2(N+1);

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic q0;
  logic load, add, shift, busy, ready, done, valid;
  logic [CW-1:0] step;

  logic         c_r = 1'b0;
  logic [N-1:0] a_r = '0;
  logic [N-1:0] q_r = '0;
  logic [N-1:0] m_r = '0;
  logic [N-1:0] m_in = '0;
  logic [N-1:0] q_in = '0;
  logic [N:0]   sum;
  logic         q0_rand = 1'b0;
  logic         use_rand = 1'b0;

  int total = 0;
  int bad   = 0;
  int ecount = 0;

  typedef struct {
    int done_e;
    int prod;
    int adds;
    bit data_ok;
  } exp_t;
  exp_t sbq[$];
  exp_t cur;

  bit active = 1'b0;
  int k_acc  = 0;
  int n_add  = 0;
  int n_shift = 0;

  mult_sequencer #(.N(N)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .q0(q0),
    .load(load), .add(add), .shift(shift), .busy(busy), .ready(ready),
    .done(done), .valid(valid), .step(step)
  );

  always #5 clock = ~clock;
  always @(posedge clock) ecount <= ecount + 1;

  // Accumulator register driven by the strobes
  assign sum = {1'b0, a_r} + {1'b0, m_r};
  assign q0  = use_rand ? q0_rand : q_r[0];

  always @(posedge clock) begin
    if (load) begin
      c_r <= 1'b0; a_r <= '0; q_r <= q_in; m_r <= m_in;
    end else if (add) begin
      c_r <= 1'b0; a_r <= sum[N:1]; q_r <= {sum[0], q_r[N-1:1]};
    end else if (shift) begin
      c_r <= 1'b0; a_r <= {c_r, a_r[N-1:1]}; q_r <= {a_r[0], q_r[N-1:1]};
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at edge %0d",
               name, act, act, exp, exp, ecount);
    end
  endtask

  task automatic set_ops(input logic [N-1:0] m, input logic [N-1:0] q);
    m_in = m;
    q_in = q;
  endtask

  // One clock of stimulus; predicts what the coming edge does to the operation timeline
  task automatic cyc(input bit st, input bit ab);
    int e;
    bit busy_now;
    start   = st;
    abort   = ab;
    q0_rand = 1'($urandom);
    e = ecount;
    busy_now = active && (e >= k_acc) && (e <= k_acc + N);
    if (!busy_now && st) begin
      k_acc  = e + 1;
      active = 1'b1;
      sbq.push_back('{e + N + 2, int'(m_in) * int'(q_in), $countones(q_in), !use_rand});
    end else if (busy_now && ab) begin
      active = 1'b0;
      sbq.delete(sbq.size() - 1);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic run_op(input logic [N-1:0] m, input logic [N-1:0] q);
    set_ops(m, q);
    cyc(1'b1, 1'b0);
    repeat (N + 1) cyc(1'b0, 1'b0);
    chk("op_done", int'(done), 1);
    cyc(1'b0, 1'b0);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      chk("strobe_onehot", int'(load) + int'(add) + int'(shift) <= 1 ? 1 : 0, 1);
      chk("ready_vs_busy", int'(ready), int'(!busy));
      if (busy) chk("valid_low_busy", int'(valid), 0);
      else chk("no_strobe_idle", int'(load | add | shift), 0);
      if (load) begin
        n_add = 0;
        n_shift = 0;
      end
      n_add   += int'(add);
      n_shift += int'(shift);
      if (done) begin
        chk("done_expected", int'(sbq.size() != 0), 1);
        if (sbq.size() != 0) begin
          cur = sbq.pop_front();
          chk("done_edge", ecount, cur.done_e);
          chk("valid_at_done", int'(valid), 1);
          chk("step_at_done", int'(step), N);
          chk("steps_per_op", n_add + n_shift, N);
          if (cur.data_ok) begin
            chk("product", int'({a_r, q_r}), cur.prod);
            chk("add_count", n_add, cur.adds);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready", int'(ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_strobes", int'(load | add | shift), 0);
    chk("rst_done_valid", int'(done | valid), 0);
    chk("rst_step", int'(step), 0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Q=0xB5, M=0x0D with per-step strobe checks
    set_ops(8'h0D, 8'hB5);
    cyc(1'b1, 1'b0);
    chk("load_cycle", int'(load), 1);
    chk("load_step0", int'(step), 0);
    chk("load_valid0", int'(valid), 0);
    cyc(1'b0, 1'b0);
    for (int i = 0; i < N; i++) begin
      chk("run_step", int'(step), i);
      chk("run_add", int'(add), int'(q_in[i]));
      chk("run_shift", int'(shift), int'(!q_in[i]));
      cyc(1'b0, 1'b0);
    end
    chk("done_pulse", int'(done), 1);
    cyc(1'b0, 1'b0);
    chk("idle_done_low", int'(done), 0);
    chk("idle_valid_held", int'(valid), 1);
    chk("idle_step_held", int'(step), N);

    run_op(8'hFF, 8'h00);
    run_op(8'hFF, 8'hFF);

    // Start held high: LOAD must follow each DONE directly
    set_ops(8'h37, 8'hC3);
    cyc(1'b1, 1'b0);
    for (int j = 0; j < 3; j++) begin
      chk("b2b_load", int'(load), 1);
      repeat (N + 1) cyc(1'b1, 1'b0);
      chk("b2b_done", int'(done), 1);
      set_ops(8'($urandom), 8'($urandom));
      cyc(j < 2, 1'b0);
    end
    cyc(1'b0, 1'b0);

    // Start during RUN step 4 is ignored
    set_ops(8'h5A, 8'h37);
    cyc(1'b1, 1'b0);
    repeat (5) cyc(1'b0, 1'b0);
    chk("ign_step4", int'(step), 4);
    cyc(1'b1, 1'b0);
    repeat (3) cyc(1'b0, 1'b0);
    chk("ign_done", int'(done), 1);
    cyc(1'b0, 1'b0);

    // Abort at RUN step 5
    set_ops(8'h21, 8'hFF);
    cyc(1'b1, 1'b0);
    repeat (6) cyc(1'b0, 1'b0);
    abort = 1'b1;
    #1;
    chk("abort_step", int'(step), 5);
    chk("abort_no_strobe", int'(add | shift), 0);
    cyc(1'b0, 1'b1);
    chk("abort_ready", int'(ready), 1);
    chk("abort_valid", int'(valid), 0);
    chk("abort_step_held", int'(step), 5);
    chk("abort_no_done", int'(done), 0);
    repeat (4) cyc(1'b0, 1'b0);

    // Start wins over abort in IDLE
    set_ops(8'h03, 8'h81);
    cyc(1'b1, 1'b1);
    chk("start_wins", int'(load), 1);
    repeat (N + 1) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);

    // Asynchronous reset at RUN step 3
    set_ops(8'h44, 8'h99);
    cyc(1'b1, 1'b0);
    repeat (4) cyc(1'b0, 1'b0);
    chk("pre_rst_step3", int'(step), 3);
    #2 reset = 1'b1;
    #1;
    chk("arst_strobes", int'(load | add | shift), 0);
    chk("arst_busy_done_valid", int'(busy | done | valid), 0);
    chk("arst_ready", int'(ready), 1);
    chk("arst_step", int'(step), 0);
    active = 1'b0;
    sbq.delete(sbq.size() - 1);
    #2 reset = 1'b0;
    set_ops(8'hE7, 8'h5D);
    cyc(1'b1, 1'b0);
    chk("post_rst_load", int'(load), 1);
    repeat (N + 1) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);

    // Random q0, start and abort
    use_rand = 1'b1;
    for (int r = 0; r < 1000; r++) begin
      set_ops(8'($urandom), 8'($urandom));
      cyc(($urandom % 4) == 0, ($urandom % 16) == 0);
    end
    use_rand = 1'b0;
    repeat (N + 4) cyc(1'b0, 1'b0);
    chk("queue_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
